// File: rtl/fixed_point_divider.sv
// Unsigned Q5.11 fixed-point divider: restoring division, one quotient bit per cycle, MSB first.
// Define DIV_SATURATE_EN to clamp the result to 0xFFFF on overflow (default build wraps to Q[15:0]).
module fixed_point_divider #(
  parameter int FRAC_BITS = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        overflow
);

  localparam int DW       = 16;
  localparam int NUM_ITER = DW + FRAC_BITS;
  localparam int CNT_W    = $clog2(NUM_ITER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   w_accept;
  logic   w_finish;

  // Working registers: r_shift holds the unconsumed dividend bits in its upper
  // part and the quotient bits gathered so far in its lower part.
  logic [NUM_ITER-1:0] r_shift;
  logic [DW-1:0]       r_rem;
  logic [DW-1:0]       r_divisor;
  logic                r_div_zero;
  logic [CNT_W-1:0]    r_count;

  logic [DW-1:0]       r_result;
  logic                r_dbz_flag;
  logic                r_ovf_flag;

  logic [DW:0]         w_rem_shift;
  logic                w_fits;
  logic [DW-1:0]       w_diff;
  logic [DW-1:0]       w_rem_next;
  logic [NUM_ITER-1:0] w_quot_next;
  logic                w_quot_ovf;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        busy = 1'b1;
        if (r_div_zero || (r_count == CNT_W'(NUM_ITER - 1))) begin
          w_finish     = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = S_BUSY;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Restoring division step
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rem_shift = {r_rem, r_shift[NUM_ITER-1]};
    w_fits      = (w_rem_shift >= {1'b0, r_divisor});
    // When the divisor fits, the difference is below the divisor and so fits DW bits.
    w_diff      = w_rem_shift[DW-1:0] - r_divisor;
    w_rem_next  = w_fits ? w_diff : w_rem_shift[DW-1:0];
    w_quot_next = {r_shift[NUM_ITER-2:0], w_fits};
    w_quot_ovf  = |w_quot_next[NUM_ITER-1:DW];
  end

  // NOTE: the working registers are not reset; each accept reloads all of
  // them before they are used, and reset alone cannot produce a done pulse.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift    <= {a, {FRAC_BITS{1'b0}}};
      r_rem      <= '0;
      r_divisor  <= b;
      r_div_zero <= (b == '0);
      r_count    <= '0;
    end else if (r_state == S_BUSY) begin
      r_shift    <= w_quot_next;
      r_rem      <= w_rem_next;
      r_count    <= r_count + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Result and status registers: written only on the edge entering DONE
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result   <= '0;
      r_dbz_flag <= 1'b0;
      r_ovf_flag <= 1'b0;
    end else if (w_finish) begin
      if (r_div_zero) begin
        r_result   <= '1;
        r_dbz_flag <= 1'b1;
        r_ovf_flag <= 1'b0;
      end else begin
        r_dbz_flag <= 1'b0;
        r_ovf_flag <= w_quot_ovf;
`ifdef DIV_SATURATE_EN
        r_result   <= w_quot_ovf ? '1 : w_quot_next[DW-1:0];
`else
        r_result   <= w_quot_next[DW-1:0];
`endif
      end
    end
  end

  assign result      = r_result;
  assign div_by_zero = r_dbz_flag;
  assign overflow    = r_ovf_flag;

endmodule
